// File: rtl/if_id_pipe_reg_pkg.sv
// Shared definitions for the fetch/decode pipeline register and its skid buffer.
// Holds the NOP encoding, the occupancy codes and small helpers.
package if_id_pipe_reg_pkg;

  localparam int          NOP_WIDTH = 16;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Upstream may push whenever the skid slot is still free.
  function automatic logic occ_can_accept(input logic [1:0] occ);
    return (occ != OCC_TWO);
  endfunction

  function automatic logic occ_is_legal(input logic [1:0] occ);
    return (occ == OCC_EMPTY) || (occ == OCC_ONE) || (occ == OCC_TWO);
  endfunction

endpackage

// File: rtl/if_id_pipe_reg_skid_buf.sv
// Generic two-entry valid/ready register with a registered in_ready.
// The head (main) entry drives the outputs; the skid entry absorbs one beat of backpressure.
module pipe_skid_buf
  import if_id_pipe_reg_pkg::*;
#(
  parameter int width = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       occ;
  logic             main_v;
  logic             skid_v;
  logic [width-1:0] main_data;
  logic [width-1:0] skid_data;
  logic             acc;
  logic             deq;

  assign in_ready  = occ_can_accept(occ);
  assign out_valid = main_v;
  assign out_data  = main_data;
  assign occupancy = occ;

  // A cleared cycle never accepts, but a same-cycle dequeue still happens downstream.
  always_comb begin
    acc = in_valid & in_ready & ~clear;
    deq = main_v & out_ready;
  end

  // Occupancy state machine and entry storage; main always holds the older entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ       <= OCC_EMPTY;
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= {width{1'b0}};
      skid_data <= {width{1'b0}};
    end else if (clear) begin
      occ    <= OCC_EMPTY;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (acc) begin
            main_data <= in_data;
            main_v    <= 1'b1;
            occ       <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (acc && deq) begin
            main_data <= in_data;
          end else if (acc) begin
            skid_data <= in_data;
            skid_v    <= 1'b1;
            occ       <= OCC_TWO;
          end else if (deq) begin
            main_v <= 1'b0;
            occ    <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (deq) begin
            main_data <= skid_data;
            skid_v    <= 1'b0;
            occ       <= OCC_ONE;
          end
        end
        default: begin
          occ    <= OCC_EMPTY;
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: wraps the skid buffer, adds redirect flush and
// substitutes the NOP encoding whenever decode has no valid instruction.
module if_id_pipe_reg
  import if_id_pipe_reg_pkg::*;
#(
  parameter int                     pc_width    = 10,
  parameter int                     instr_width = 16,
  parameter logic [instr_width-1:0] nop_instr   = instr_width'(NOP_INSTR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_if,
  output logic                   ready_if,
  input  logic [pc_width-1:0]    pc_curr_if,
  input  logic [instr_width-1:0] instr_if,
  output logic                   valid_id,
  input  logic                   ready_id,
  output logic [pc_width-1:0]    pc_curr_id,
  output logic [instr_width-1:0] instr_id,
  input  logic                   flush,
  output logic [1:0]             occupancy
);

  localparam int bus_width = pc_width + instr_width;

  logic [bus_width-1:0]   in_bus;
  logic [bus_width-1:0]   head_bus;
  logic                   head_v;
  logic [instr_width-1:0] head_instr;

  assign in_bus = {pc_curr_if, instr_if};

  pipe_skid_buf #(
    .width(bus_width)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .in_valid (valid_if),
    .in_ready (ready_if),
    .in_data  (in_bus),
    .out_valid(head_v),
    .out_ready(ready_id),
    .out_data (head_bus),
    .occupancy(occupancy)
  );

  assign valid_id   = head_v;
  assign pc_curr_id = head_bus[bus_width-1:instr_width];
  assign head_instr = head_bus[instr_width-1:0];

  // PC stays held when invalid; only the instruction word is masked.
  always_comb begin
    if (head_v) begin
      instr_id = head_instr;
    end else begin
      instr_id = nop_instr;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: stimulus pushes accepted beats into a
// reference queue, a negedge monitor pops and compares on every dequeue.
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_if = 1'b0;
  logic        ready_if;
  logic [9:0]  pc_curr_if = 10'd0;
  logic [15:0] instr_if = 16'd0;
  logic        valid_id;
  logic        ready_id = 1'b0;
  logic [9:0]  pc_curr_id;
  logic [15:0] instr_id;
  logic        flush = 1'b0;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_q[$];
  bit          model_ready = 1'b1;

  if_id_pipe_reg dut (
    .clk       (clk),
    .rst       (rst),
    .valid_if  (valid_if),
    .ready_if  (ready_if),
    .pc_curr_if(pc_curr_if),
    .instr_if  (instr_if),
    .valid_id  (valid_id),
    .ready_id  (ready_id),
    .pc_curr_id(pc_curr_id),
    .instr_id  (instr_id),
    .flush     (flush),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: capture accepted beats at the clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else if (valid_if && model_ready) begin
      exp_q.push_back({pc_curr_if, instr_if});
    end
  end

  // Monitor: compare state/head each cycle, pop when decode consumes.
  always @(negedge clk) begin
    if (!rst) begin
      model_ready = (exp_q.size() < 2);
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("ready_if", 32'(ready_if), 32'(model_ready));
      chk("valid_id", 32'(valid_id), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("head_pc", 32'(pc_curr_id), 32'(exp_q[0][25:16]));
        chk("head_instr", 32'(instr_id), 32'(exp_q[0][15:0]));
        if (ready_id) begin
          void'(exp_q.pop_front());
        end
      end else begin
        chk("nop_when_invalid", 32'(instr_id), 32'h0);
      end
    end
  end

  task automatic cyc(input bit v, input logic [9:0] pc, input bit rdy, input bit fl);
    valid_if   = v;
    pc_curr_if = pc;
    instr_if   = 16'h1000 + 16'(pc);
    ready_id   = rdy;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with fetch asserting valid.
    valid_if = 1'b1;
    pc_curr_if = 10'h3FF;
    instr_if = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid_id", 32'(valid_id), 32'h0);
      chk("rst_instr_id", 32'(instr_id), 32'h0);
      chk("rst_ready_if", 32'(ready_if), 32'h1);
      chk("rst_occupancy", 32'(occupancy), 32'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming.
    for (int p = 0; p < 8; p++) cyc(1'b1, 10'(p), 1'b1, 1'b0);
    cyc(1'b0, 10'h0, 1'b1, 1'b0);

    // Backpressure into the skid slot.
    cyc(1'b1, 10'h010, 1'b0, 1'b0);
    cyc(1'b1, 10'h011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 10'h012, 1'b0, 1'b0);
    chk("bp_occupancy", 32'(occupancy), 32'h2);
    chk("bp_pc_frozen", 32'(pc_curr_id), 32'h010);
    cyc(1'b1, 10'h012, 1'b1, 1'b0);
    cyc(1'b0, 10'h0, 1'b1, 1'b0);
    cyc(1'b0, 10'h0, 1'b1, 1'b0);
    cyc(1'b0, 10'h0, 1'b1, 1'b0);

    // Flush while full, with a same-cycle incoming beat.
    cyc(1'b1, 10'h020, 1'b0, 1'b0);
    cyc(1'b1, 10'h021, 1'b0, 1'b0);
    cyc(1'b1, 10'h022, 1'b0, 1'b1);
    chk("flush_valid_id", 32'(valid_id), 32'h0);
    chk("flush_instr_id", 32'(instr_id), 32'h0);
    chk("flush_occupancy", 32'(occupancy), 32'h0);
    cyc(1'b1, 10'h030, 1'b1, 1'b0);
    chk("post_flush_pc", 32'(pc_curr_id), 32'h030);
    cyc(1'b0, 10'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges while full.
    cyc(1'b1, 10'h040, 1'b0, 1'b0);
    cyc(1'b1, 10'h041, 1'b0, 1'b0);
    cyc(1'b0, 10'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid_id", 32'(valid_id), 32'h0);
    chk("arst_occupancy", 32'(occupancy), 32'h0);
    chk("arst_ready_if", 32'(ready_if), 32'h1);
    chk("arst_pc_id", 32'(pc_curr_id), 32'h0);
    chk("arst_instr_id", 32'(instr_id), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Random soak against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      valid_if   = 1'($urandom_range(0, 1));
      pc_curr_if = 10'($urandom);
      instr_if   = 16'($urandom);
      ready_id   = 1'($urandom_range(0, 1));
      flush      = ($urandom_range(0, 99) < 5);
      @(posedge clk);
      #1;
    end
    valid_if = 1'b0;
    flush    = 1'b0;
    ready_id = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drained_occupancy", 32'(occupancy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
